// File: rtl/prog_accumulator_pkg.sv
// Shared definitions for the programmable accumulator: opcode values and mode encoding.
package prog_accumulator_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_ACC     = 3'b001;
    localparam logic [2:0] OP_MAC     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_POPCNT  = 3'b100;
    localparam logic [2:0] OP_REV     = 3'b101;
    localparam logic [2:0] OP_SETLOOP = 3'b110;
    localparam logic [2:0] OP_RSVD    = 3'b111;

    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_CALC = 1'b1
    } mode_e;

endpackage

// File: rtl/prog_accumulator_if.sv
// Instruction/step inputs and status outputs of the programmable accumulator.
interface prog_accumulator_if #(
    parameter int DATA_W = 10,
    parameter int VAL_W  = 4,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              mode;
    logic              in_valid;
    logic [2:0]        opCode;
    logic [VAL_W-1:0]  value;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              cacheFull;
    logic              invalidOp;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output mode, in_valid, opCode, value,
        input  result, result_valid, cacheFull, invalidOp, overflow, count
    );

    modport slave (
        input  mode, in_valid, opCode, value,
        output result, result_valid, cacheFull, invalidOp, overflow, count
    );
endinterface

// File: rtl/prog_accumulator_acc_alu.sv
// Combinational arithmetic for one accumulator step; computes at full width,
// then wraps or clamps into DATA_W bits depending on SAT.
module acc_alu
    import prog_accumulator_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int VAL_W  = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    input  logic [VAL_W-1:0]  v,
    output logic [DATA_W-1:0] new_p0,
    output logic              ovf
);
    // Wide enough for p0*p1+v without loss.
    localparam int WIDE_W = 2 * DATA_W + 2;

    logic [WIDE_W-1:0] wide;
    logic [WIDE_W-1:0] pop;
    logic [DATA_W-1:0] rev;
    logic              under;
    logic              over;

    always_comb begin
        pop   = '0;
        rev   = '0;
        wide  = '0;
        under = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            pop    = pop + WIDE_W'(p0[i]);
            rev[i] = p0[DATA_W-1-i];
        end
        case (op)
            OP_ADD:    wide = WIDE_W'(p0) + WIDE_W'(v);
            OP_ACC:    wide = WIDE_W'(p0) + WIDE_W'(p1) + WIDE_W'(v);
            OP_MAC:    wide = WIDE_W'(p0) * WIDE_W'(p1) + WIDE_W'(v);
            OP_SUB: begin
                wide  = WIDE_W'(p0) - WIDE_W'(v);
                under = WIDE_W'(p0) < WIDE_W'(v);
            end
            OP_POPCNT: wide = pop;
            OP_REV:    wide = WIDE_W'(rev);
            default:   wide = WIDE_W'(p0);
        endcase
        // A SUB borrow also sets the high bits, so it must not count as overflow above.
        over = (|wide[WIDE_W-1:DATA_W]) & ~under;
        ovf  = over | under;
        if (SAT && over) begin
            new_p0 = '1;
        end else if (SAT && under) begin
            new_p0 = '0;
        end else begin
            new_p0 = wide[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/prog_accumulator.sv
// Programmable accumulator: loads {opCode,value} instructions into a cache and
// replays them cyclically from a programmable loop start in calc mode.
module prog_accumulator
    import prog_accumulator_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int VAL_W  = 4,
    parameter int DEPTH  = 32,
    parameter bit SAT    = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    prog_accumulator_if.slave  bus
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PC_W    = $clog2(DEPTH);
    localparam int INSTR_W = 3 + VAL_W;

    logic [DATA_W-1:0] p0_q, p0_d;
    logic [DATA_W-1:0] p1_q, p1_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   loop_start_q, loop_start_d;
    logic              result_valid_q, result_valid_d;
    logic              invalid_op_q, invalid_op_d;
    logic              overflow_q, overflow_d;

    logic [INSTR_W-1:0] cache_mem [DEPTH];
    logic               cache_we;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         instr_op;
    logic [VAL_W-1:0]   instr_val;
    logic [DATA_W-1:0]  alu_p0;
    logic               alu_ovf;
    logic               cache_full;

    assign instr      = cache_mem[pc_q];
    assign instr_op   = instr[INSTR_W-1 -: 3];
    assign instr_val  = instr[VAL_W-1:0];
    assign cache_full = (count_q == CNT_W'(DEPTH));

    acc_alu #(
        .DATA_W (DATA_W),
        .VAL_W  (VAL_W),
        .SAT    (SAT)
    ) u_alu (
        .op     (instr_op),
        .p0     (p0_q),
        .p1     (p1_q),
        .v      (instr_val),
        .new_p0 (alu_p0),
        .ovf    (alu_ovf)
    );

    always_comb begin
        p0_d           = p0_q;
        p1_d           = p1_q;
        result_d       = result_q;
        count_d        = count_q;
        pc_d           = pc_q;
        loop_start_d   = loop_start_q;
        result_valid_d = 1'b0;
        invalid_op_d   = invalid_op_q;
        overflow_d     = overflow_q;
        cache_we       = 1'b0;

        if (bus.in_valid) begin
            if (bus.mode == MODE_LOAD) begin
                if (bus.opCode == OP_RSVD) begin
                    invalid_op_d = 1'b1;
                end else if (cache_full) begin
                    invalid_op_d = 1'b0;
                end else begin
                    cache_we     = 1'b1;
                    count_d      = count_q + CNT_W'(1);
                    invalid_op_d = 1'b0;
                    pc_d         = loop_start_q;
                end
            end else begin
                invalid_op_d = 1'b0;
                if (count_q == '0) begin
                    p1_d           = p0_q;
                    p0_d           = '0;
                    result_d       = '0;
                    result_valid_d = 1'b1;
                    overflow_d     = 1'b0;
                end else begin
                    if (instr_op == OP_SETLOOP) begin
                        if (32'(instr_val) < 32'(count_q)) begin
                            loop_start_d = PC_W'(instr_val);
                        end else begin
                            invalid_op_d = 1'b1;
                        end
                    end else begin
                        p1_d           = p0_q;
                        p0_d           = alu_p0;
                        result_d       = alu_p0;
                        result_valid_d = 1'b1;
                        overflow_d     = alu_ovf;
                    end
                    // Wrap uses the next loop start so a trailing SETLOOP applies immediately.
                    if (CNT_W'(pc_q) == count_q - CNT_W'(1)) begin
                        pc_d = loop_start_d;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_q           <= '0;
            p1_q           <= '0;
            result_q       <= '0;
            count_q        <= '0;
            pc_q           <= '0;
            loop_start_q   <= '0;
            result_valid_q <= 1'b0;
            invalid_op_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            p0_q           <= p0_d;
            p1_q           <= p1_d;
            result_q       <= result_d;
            count_q        <= count_d;
            pc_q           <= pc_d;
            loop_start_q   <= loop_start_d;
            result_valid_q <= result_valid_d;
            invalid_op_q   <= invalid_op_d;
            overflow_q     <= overflow_d;
        end
    end

    // Cache contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (cache_we) begin
            cache_mem[PC_W'(count_q)] <= {bus.opCode, bus.value};
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.cacheFull    = cache_full;
    assign bus.invalidOp    = invalid_op_q;
    assign bus.overflow     = overflow_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_prog_accumulator.sv
// Bench for prog_accumulator: wrapping and saturating instances driven in lockstep,
// checked against constant vectors and a queue-based program model.
module tb_prog_accumulator;
    import prog_accumulator_pkg::*;

    localparam int DATA_W = 10;
    localparam int VAL_W  = 4;
    localparam int DEPTH  = 32;
    localparam longint MAXV = (longint'(1) << DATA_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    prog_accumulator_if #(.DATA_W(DATA_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) bus_w ();
    prog_accumulator_if #(.DATA_W(DATA_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) bus_s ();

    prog_accumulator #(.DATA_W(DATA_W), .VAL_W(VAL_W), .DEPTH(DEPTH), .SAT(1'b0)) dut_w (
        .clk(clk), .reset_n(reset_n), .bus(bus_w));
    prog_accumulator #(.DATA_W(DATA_W), .VAL_W(VAL_W), .DEPTH(DEPTH), .SAT(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s));

    int checks = 0;
    int errors = 0;

    int     q_op[$];
    int     q_val[$];
    int     m_pc, m_loop;
    longint m_p0[2], m_p1[2];
    int     m_res[2];
    int     m_ovf[2];
    int     m_rv, m_inv;

    typedef struct {
        int rst; int mode; int vld; int op; int val;
        int res_w; int res_s; int rv; int ovf_w; int ovf_s; int inv; int cnt;
    } vec_t;
    vec_t vecs[$];

    // Spec-level value of one arithmetic op, before any wrapping or clamping.
    function automatic longint true_value(int op, longint a, longint b, int v);
        longint r;
        case (op)
            0: return a + v;
            1: return a + b + v;
            2: return a * b + v;
            3: return a - v;
            4: return longint'($countones(a));
            5: begin
                r = 0;
                for (int i = 0; i < DATA_W; i++) r = r | (((a >> i) & 1) << (DATA_W - 1 - i));
                return r;
            end
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        q_op.delete();
        q_val.delete();
        m_pc = 0; m_loop = 0; m_rv = 0; m_inv = 0;
        for (int s = 0; s < 2; s++) begin
            m_p0[s] = 0; m_p1[s] = 0; m_res[s] = 0; m_ovf[s] = 0;
        end
    endtask

    task automatic model_step(int mode, int vld, int op, int val);
        longint t;
        int     iop, ival, n;
        m_rv = 0;
        if (vld == 0) return;
        n = q_op.size();
        if (mode == 0) begin
            if (op == 7) m_inv = 1;
            else if (n == DEPTH) m_inv = 0;
            else begin
                q_op.push_back(op); q_val.push_back(val);
                m_inv = 0; m_pc = m_loop;
            end
        end else begin
            m_inv = 0;
            if (n == 0) begin
                for (int s = 0; s < 2; s++) begin
                    m_p1[s] = m_p0[s]; m_p0[s] = 0; m_res[s] = 0; m_ovf[s] = 0;
                end
                m_rv = 1;
            end else begin
                iop = q_op[m_pc]; ival = q_val[m_pc];
                if (iop == 6) begin
                    if (ival < n) m_loop = ival;
                    else m_inv = 1;
                end else begin
                    for (int s = 0; s < 2; s++) begin
                        t = true_value(iop, m_p0[s], m_p1[s], ival);
                        m_ovf[s] = (t > MAXV || t < 0) ? 1 : 0;
                        m_p1[s] = m_p0[s];
                        if (s == 1) m_p0[s] = (t > MAXV) ? MAXV : ((t < 0) ? 0 : t);
                        else        m_p0[s] = t & MAXV;
                        m_res[s] = int'(m_p0[s]);
                    end
                    m_rv = 1;
                end
                m_pc = (m_pc == n - 1) ? m_loop : m_pc + 1;
            end
        end
    endtask

    task automatic drive(int mode, int vld, int op, int val);
        bus_w.mode = mode[0]; bus_w.in_valid = vld[0];
        bus_w.opCode = 3'(op); bus_w.value = VAL_W'(val);
        bus_s.mode = mode[0]; bus_s.in_valid = vld[0];
        bus_s.opCode = 3'(op); bus_s.value = VAL_W'(val);
    endtask

    task automatic applyStimulus(int mode, int vld, int op, int val);
        drive(mode, vld, op, val);
        @(posedge clk);
        #1;
        model_step(mode, vld, op, val);
    endtask

    task automatic checkOutput(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkModel(string tag);
        checkOutput({tag, " result_w"}, int'(bus_w.result), m_res[0]);
        checkOutput({tag, " result_s"}, int'(bus_s.result), m_res[1]);
        checkOutput({tag, " rv_w"}, int'(bus_w.result_valid), m_rv);
        checkOutput({tag, " rv_s"}, int'(bus_s.result_valid), m_rv);
        checkOutput({tag, " ovf_w"}, int'(bus_w.overflow), m_ovf[0]);
        checkOutput({tag, " ovf_s"}, int'(bus_s.overflow), m_ovf[1]);
        checkOutput({tag, " inv_w"}, int'(bus_w.invalidOp), m_inv);
        checkOutput({tag, " inv_s"}, int'(bus_s.invalidOp), m_inv);
        checkOutput({tag, " count_w"}, int'(bus_w.count), q_op.size());
        checkOutput({tag, " count_s"}, int'(bus_s.count), q_op.size());
        checkOutput({tag, " full_w"}, int'(bus_w.cacheFull), (q_op.size() == DEPTH) ? 1 : 0);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic add_vec(int rst, int mode, int vld, int op, int val,
                           int res_w, int res_s, int rv, int ovf_w, int ovf_s, int inv, int cnt);
        vec_t v;
        v = '{rst, mode, vld, op, val, res_w, res_s, rv, ovf_w, ovf_s, inv, cnt};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        int   mode, vld, op, val;

        // ADD 5, ADD 3 then four steps and one idle cycle
        add_vec(1,0,1,0,5,   0,0,0,0,0,0,1);
        add_vec(0,0,1,0,3,   0,0,0,0,0,0,2);
        add_vec(0,1,1,0,0,   5,5,1,0,0,0,2);
        add_vec(0,1,1,0,0,   8,8,1,0,0,0,2);
        add_vec(0,1,1,0,0,  13,13,1,0,0,0,2);
        add_vec(0,1,1,0,0,  16,16,1,0,0,0,2);
        add_vec(0,1,0,0,0,  16,16,0,0,0,0,2);
        // Empty cache calc, then ADD 1, ACC 0
        add_vec(1,1,1,0,0,   0,0,1,0,0,0,0);
        add_vec(0,0,1,0,1,   0,0,0,0,0,0,1);
        add_vec(0,0,1,1,0,   0,0,0,0,0,0,2);
        add_vec(0,1,1,0,0,   1,1,1,0,0,0,2);
        add_vec(0,1,1,0,0,   1,1,1,0,0,0,2);
        add_vec(0,1,1,0,0,   2,2,1,0,0,0,2);
        add_vec(0,1,1,0,0,   3,3,1,0,0,0,2);
        // ADD 15, ADD 15, MAC 0
        add_vec(1,0,1,0,15,  0,0,0,0,0,0,1);
        add_vec(0,0,1,0,15,  0,0,0,0,0,0,2);
        add_vec(0,0,1,2,0,   0,0,0,0,0,0,3);
        add_vec(0,1,1,0,0,  15,15,1,0,0,0,3);
        add_vec(0,1,1,0,0,  30,30,1,0,0,0,3);
        add_vec(0,1,1,0,0, 450,450,1,0,0,0,3);
        add_vec(0,1,1,0,0, 465,465,1,0,0,0,3);
        add_vec(0,1,1,0,0, 480,480,1,0,0,0,3);
        add_vec(0,1,1,0,0, 992,1023,1,1,1,0,3);
        // SUB 1 from zero
        add_vec(1,0,1,3,1,   0,0,0,0,0,0,1);
        add_vec(0,1,1,0,0, 1023,0,1,1,1,0,1);
        // ADD 1, SETLOOP 2, ADD 2
        add_vec(1,0,1,0,1,   0,0,0,0,0,0,1);
        add_vec(0,0,1,6,2,   0,0,0,0,0,0,2);
        add_vec(0,0,1,0,2,   0,0,0,0,0,0,3);
        add_vec(0,1,1,0,0,   1,1,1,0,0,0,3);
        add_vec(0,1,1,0,0,   1,1,0,0,0,0,3);
        add_vec(0,1,1,0,0,   3,3,1,0,0,0,3);
        add_vec(0,1,1,0,0,   5,5,1,0,0,0,3);
        add_vec(0,1,1,0,0,   7,7,1,0,0,0,3);

        drive(0, 0, 0, 0);
        doReset();
        checkOutput("reset result", int'(bus_w.result), 0);
        checkOutput("reset count", int'(bus_w.count), 0);
        checkOutput("reset flags", int'({bus_w.result_valid, bus_w.invalidOp, bus_w.overflow, bus_w.cacheFull}), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst != 0) doReset();
            applyStimulus(v.mode, v.vld, v.op, v.val);
            checkOutput($sformatf("vec%0d result_w", i), int'(bus_w.result), v.res_w);
            checkOutput($sformatf("vec%0d result_s", i), int'(bus_s.result), v.res_s);
            checkOutput($sformatf("vec%0d rv", i), int'(bus_w.result_valid), v.rv);
            checkOutput($sformatf("vec%0d ovf_w", i), int'(bus_w.overflow), v.ovf_w);
            checkOutput($sformatf("vec%0d ovf_s", i), int'(bus_s.overflow), v.ovf_s);
            checkOutput($sformatf("vec%0d inv", i), int'(bus_w.invalidOp), v.inv);
            checkOutput($sformatf("vec%0d count", i), int'(bus_w.count), v.cnt);
        end

        // Out-of-range SETLOOP leaves the loop start at 0
        doReset();
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 6, 5);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("setloop_bad inv", int'(bus_w.invalidOp), 1);
        checkOutput("setloop_bad result", int'(bus_w.result), 2);
        checkOutput("setloop_bad rv", int'(bus_w.result_valid), 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("setloop_bad wrap result", int'(bus_w.result), 3);
        checkOutput("setloop_bad inv clear", int'(bus_w.invalidOp), 0);
        checkModel("setloop_bad");

        // Fill beyond depth
        doReset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(0, 1, 0, i % 16);
            if (i == DEPTH - 2) checkOutput("fill31 full", int'(bus_w.cacheFull), 0);
            if (i == DEPTH - 1) begin
                checkOutput("fill32 full", int'(bus_w.cacheFull), 1);
                checkOutput("fill32 count", int'(bus_w.count), 32);
            end
        end
        checkOutput("fill33 count", int'(bus_w.count), 32);
        checkOutput("fill33 full", int'(bus_w.cacheFull), 1);
        checkOutput("fill33 inv", int'(bus_w.invalidOp), 0);

        // Reserved opcode
        doReset();
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 7, 3);
        checkOutput("rsvd inv", int'(bus_w.invalidOp), 1);
        checkOutput("rsvd count", int'(bus_w.count), 1);
        applyStimulus(0, 1, 0, 2);
        checkOutput("rsvd then load inv", int'(bus_w.invalidOp), 0);
        checkOutput("rsvd then load count", int'(bus_w.count), 2);

        // Asynchronous reset between clock edges
        doReset();
        applyStimulus(0, 1, 3, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("pre_areset result", int'(bus_w.result), 1023);
        checkOutput("pre_areset ovf", int'(bus_w.overflow), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset result", int'(bus_w.result), 0);
        checkOutput("areset ovf", int'(bus_w.overflow), 0);
        checkOutput("areset rv", int'(bus_w.result_valid), 0);
        checkOutput("areset count", int'(bus_w.count), 0);
        doReset();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) doReset();
            mode = ($urandom_range(99) < 55) ? 1 : 0;
            vld  = ($urandom_range(9) != 0) ? 1 : 0;
            op   = int'($urandom_range(7));
            val  = int'($urandom_range(15));
            applyStimulus(mode, vld, op, val);
            checkModel("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
